// File: rtl/frame_loader_if.sv
// Valid/ready pixel stream carrying one pixel word per beat plus a start-of-frame flag.
// The master is the upstream pixel source; the slave is frame_loader.
interface frame_loader_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] px_data;
  logic              px_valid;
  logic              px_sof;
  logic              px_ready;

  modport master (output px_data, px_valid, px_sof, input px_ready);
  modport slave  (input px_data, px_valid, px_sof, output px_ready);
endinterface

// File: rtl/frame_loader.sv
// Loads whole frames into the back half of pixel_ram and swaps the display/back halves
// only on panel_driver's end-of-refresh pulse. The reset input is active low.
module frame_loader #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int FRAME_WORDS = 2048
) (
  input  logic              clk_48mhz,
  input  logic              reset,
  frame_loader_if.slave     px,
  input  logic              frame_done,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              ram_w_stb,
  output logic              display_bank,
  output logic              swap,
  output logic              sync_err,
  output logic [7:0]        frame_count
);
  localparam int              OFF_W = ADDR_W - 1;
  localparam logic [OFF_W-1:0] LAST  = OFF_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;

  state_t           state_q, state_d;
  logic [OFF_W-1:0] off_q, off_d, wr_off;
  logic [1:0]       rst_sync;
  logic             rst_n;
  logic             ready, accept, wr_en, err_d, swap_d;

  // Assert asynchronously, release two clocks after the external reset deasserts.
  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign px.px_ready = ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    off_d   = off_q;
    wr_off  = off_q;
    wr_en   = 1'b0;
    err_d   = 1'b0;
    swap_d  = 1'b0;
    ready   = rst_n && (state_q != WAIT_SWAP);
    accept  = px.px_valid && ready;
    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (px.px_sof) begin
            // A sof always restarts the frame; mid-frame it also flags a resync.
            wr_en  = 1'b1;
            wr_off = '0;
            err_d  = (state_q == LOAD);
          end else if (state_q == LOAD) begin
            wr_en = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (wr_en) begin
            if (wr_off == LAST) begin
              state_d = WAIT_SWAP;
              off_d   = '0;
            end else begin
              state_d = LOAD;
              off_d   = wr_off + 1'b1;
            end
          end
        end
      end
      WAIT_SWAP: begin
        if (frame_done) begin
          swap_d  = 1'b1;
          off_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The back bank is always the complement of the displayed one.
  // NOTE: data/address registers are reset too, so every output reads 0 while in reset.
  always_ff @(posedge clk_48mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      off_q        <= '0;
      ram_w_stb    <= 1'b0;
      ram_w_addr   <= '0;
      ram_w_data   <= '0;
      display_bank <= 1'b0;
      swap         <= 1'b0;
      sync_err     <= 1'b0;
      frame_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q   <= state_d;
      off_q     <= off_d;
      ram_w_stb <= wr_en;
      swap      <= swap_d;
      sync_err  <= err_d;
      if (wr_en) begin
        ram_w_addr <= {~display_bank, wr_off};
        ram_w_data <= px.px_data;
      end
      if (swap_d) begin
        display_bank <= ~display_bank;
        frame_count  <= frame_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_frame_loader.sv
// Randomized bench for frame_loader: expected RAM writes are derived from frame/bank
// arithmetic and compared with every write strobe the DUT issues.
module tb_frame_loader;
  localparam int FW = 2048;

  logic        clk_48mhz = 1'b0;
  logic        reset;
  logic        frame_done;
  logic [11:0] ram_w_addr;
  logic [15:0] ram_w_data;
  logic        ram_w_stb, display_bank, swap, sync_err;
  logic [7:0]  frame_count;

  frame_loader_if #(.DATA_W(16)) px_bus ();

  frame_loader #(.ADDR_W(12), .DATA_W(16), .FRAME_WORDS(FW)) dut (
    .clk_48mhz   (clk_48mhz),
    .reset       (reset),
    .px          (px_bus),
    .frame_done  (frame_done),
    .ram_w_addr  (ram_w_addr),
    .ram_w_data  (ram_w_data),
    .ram_w_stb   (ram_w_stb),
    .display_bank(display_bank),
    .swap        (swap),
    .sync_err    (sync_err),
    .frame_count (frame_count)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  int checks   = 0;
  int failures = 0;
  int swap_cnt = 0;
  int err_cnt  = 0;
  logic [27:0] got_q[$];
  logic [27:0] exp_q[$];

  // Reference state: which bank is displayed and how many swaps have happened.
  bit       m_disp  = 1'b0;
  bit [7:0] m_count = 8'd0;

  always @(negedge clk_48mhz) begin
    if (ram_w_stb) begin
      got_q.push_back({ram_w_addr, ram_w_data});
      checks++;
      if (ram_w_addr[11] === display_bank) begin
        failures++;
        $display("FAIL bank_overlap addr=%h display_bank=%b required addr MSB != display_bank",
                 ram_w_addr, display_bank);
      end
    end
    if (swap)     swap_cnt++;
    if (sync_err) err_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

  function automatic int first_mismatch();
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic send_beat(input logic [15:0] d, input bit s, input bit fd, input int gap,
                           output bit ok);
    int n = 0;
    repeat ($urandom_range(0, gap)) @(negedge clk_48mhz);
    @(negedge clk_48mhz);
    px_bus.px_data  = d;
    px_bus.px_valid = 1'b1;
    px_bus.px_sof   = s;
    frame_done      = fd;
    while (!px_bus.px_ready && n < 100) begin
      @(negedge clk_48mhz);
      n++;
    end
    ok = px_bus.px_ready;
    @(posedge clk_48mhz);
    #1;
    px_bus.px_valid = 1'b0;
    px_bus.px_sof   = 1'b0;
    frame_done      = 1'b0;
  endtask

  // Sends beats first..last-1 of a frame starting at offset `first`, sof on offset 0.
  task automatic send_span(input int first, input int last, input int gap, inout int tmo);
    bit ok;
    logic [15:0] d;
    logic [11:0] base = m_disp ? 12'h000 : 12'h800;
    for (int i = first; i < last; i++) begin
      d = 16'($urandom);
      exp_q.push_back({base + 12'(i), d});
      send_beat(d, i == 0, 1'b0, gap, ok);
      if (!ok) tmo++;
    end
  endtask

  task automatic pulse_frame_done();
    @(negedge clk_48mhz);
    frame_done = 1'b1;
    @(negedge clk_48mhz);
    frame_done = 1'b0;
    repeat (2) @(negedge clk_48mhz);
    #1;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk_48mhz);
    #1;
  endtask

  task automatic check_swap(input string name, input int swaps_before);
    m_disp  = ~m_disp;
    m_count = m_count + 8'd1;
    checks++;
    if (swap_cnt - swaps_before !== 1) begin
      failures++;
      $display("FAIL %s_swap_pulses got=%0d required=1", name, swap_cnt - swaps_before);
    end
    checks++;
    if (display_bank !== m_disp) begin
      failures++;
      $display("FAIL %s_display_bank got=%b required=%b", name, display_bank, m_disp);
    end
    checks++;
    if (frame_count !== m_count) begin
      failures++;
      $display("FAIL %s_frame_count got=%0d required=%0d", name, frame_count, m_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    frame_done = 1'b0;
    px_bus.px_valid = 1'b0;
    px_bus.px_sof = 1'b0;
    px_bus.px_data = '0;
    repeat (3) @(negedge clk_48mhz);
    #1;
    checks++;
    if ({px_bus.px_ready, ram_w_stb, swap, sync_err, display_bank, frame_count, ram_w_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs ready=%b stb=%b swap=%b err=%b bank=%b count=%0d addr=%h required all 0",
               px_bus.px_ready, ram_w_stb, swap, sync_err, display_bank, frame_count, ram_w_addr);
    end
    @(negedge clk_48mhz);
    reset = 1'b1;
    repeat (4) @(negedge clk_48mhz);
    #1;
    checks++;
    if (px_bus.px_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle_ready got=%b required=1", px_bus.px_ready);
    end
  endtask

  task automatic test_frame(input string name, input int gap);
    int tmo = 0;
    int bad, sw0;
    got_q.delete();
    exp_q.delete();
    send_span(0, FW, gap, tmo);
    settle();
    bad = first_mismatch();
    checks++;
    if (bad != -1 || tmo != 0) begin
      failures++;
      $display("FAIL %s_writes first_bad_idx=%0d got_n=%0d required_n=%0d timeouts=%0d",
               name, bad, got_q.size(), exp_q.size(), tmo);
    end
    checks++;
    if (px_bus.px_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_wait_ready got=%b required=0", name, px_bus.px_ready);
    end
    sw0 = swap_cnt;
    pulse_frame_done();
    check_swap(name, sw0);
  endtask

  task automatic test_idle_drop();
    bit ok;
    int e0 = err_cnt;
    got_q.delete();
    for (int i = 0; i < 3; i++) send_beat(16'($urandom), 1'b0, 1'b0, 0, ok);
    settle();
    checks++;
    if (err_cnt - e0 !== 3) begin
      failures++;
      $display("FAIL idle_drop_sync_err got=%0d required=3", err_cnt - e0);
    end
    checks++;
    if (got_q.size() !== 0) begin
      failures++;
      $display("FAIL idle_drop_writes got=%0d required=0", got_q.size());
    end
  endtask

  task automatic test_resync();
    int tmo = 0;
    int bad, e0, sw0;
    bit ok;
    logic [15:0] d;
    logic [11:0] base = m_disp ? 12'h000 : 12'h800;
    got_q.delete();
    exp_q.delete();
    send_span(0, 100, 1, tmo);
    e0 = err_cnt;
    d = 16'($urandom);
    exp_q.push_back({base, d});
    send_beat(d, 1'b1, 1'b0, 0, ok);
    send_span(1, FW - 1, 1, tmo);
    checks++;
    if (px_bus.px_ready !== 1'b1) begin
      failures++;
      $display("FAIL resync_ready_before_last got=%b required=1", px_bus.px_ready);
    end
    send_span(FW - 1, FW, 0, tmo);
    settle();
    checks++;
    if (err_cnt - e0 !== 1) begin
      failures++;
      $display("FAIL resync_sync_err got=%0d required=1", err_cnt - e0);
    end
    checks++;
    if (px_bus.px_ready !== 1'b0) begin
      failures++;
      $display("FAIL resync_wait_ready got=%b required=0", px_bus.px_ready);
    end
    bad = first_mismatch();
    checks++;
    if (bad != -1 || tmo != 0) begin
      failures++;
      $display("FAIL resync_writes first_bad_idx=%0d got_n=%0d required_n=%0d timeouts=%0d",
               bad, got_q.size(), exp_q.size(), tmo);
    end
    sw0 = swap_cnt;
    pulse_frame_done();
    check_swap("resync", sw0);
  endtask

  task automatic test_coincident_done();
    int tmo = 0;
    int sw0, bad, not_idle = 0, nwrites;
    bit ok;
    logic [15:0] d;
    logic [11:0] base = m_disp ? 12'h000 : 12'h800;
    got_q.delete();
    exp_q.delete();
    send_span(0, FW - 1, 0, tmo);
    sw0 = swap_cnt;
    d = 16'($urandom);
    exp_q.push_back({base + 12'(FW - 1), d});
    send_beat(d, 1'b0, 1'b1, 0, ok);
    if (!ok) tmo++;
    settle();
    nwrites = got_q.size();
    // Offer a beat throughout WAIT_SWAP; it must never be taken.
    @(negedge clk_48mhz);
    px_bus.px_valid = 1'b1;
    px_bus.px_data  = 16'($urandom);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_48mhz);
      if (px_bus.px_ready !== 1'b0) not_idle++;
    end
    px_bus.px_valid = 1'b0;
    settle();
    checks++;
    if (swap_cnt !== sw0) begin
      failures++;
      $display("FAIL coincident_no_swap got=%0d required=%0d", swap_cnt, sw0);
    end
    checks++;
    if (not_idle !== 0 || got_q.size() !== nwrites) begin
      failures++;
      $display("FAIL coincident_wait_blocked ready_high_cycles=%0d extra_writes=%0d required=0,0",
               not_idle, got_q.size() - nwrites);
    end
    bad = first_mismatch();
    checks++;
    if (bad != -1 || tmo != 0) begin
      failures++;
      $display("FAIL coincident_writes first_bad_idx=%0d got_n=%0d required_n=%0d timeouts=%0d",
               bad, got_q.size(), exp_q.size(), tmo);
    end
    pulse_frame_done();
    check_swap("coincident", sw0);
  endtask

  task automatic test_reset_mid_load();
    int tmo = 0;
    got_q.delete();
    exp_q.delete();
    send_span(0, 50, 0, tmo);
    @(negedge clk_48mhz);
    reset = 1'b0;
    #1;
    checks++;
    if ({px_bus.px_ready, ram_w_stb, swap, sync_err, display_bank, frame_count,
         ram_w_addr, ram_w_data} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs ready=%b stb=%b swap=%b err=%b bank=%b count=%0d addr=%h data=%h required all 0",
               px_bus.px_ready, ram_w_stb, swap, sync_err, display_bank, frame_count,
               ram_w_addr, ram_w_data);
    end
    m_disp  = 1'b0;
    m_count = 8'd0;
    repeat (2) @(negedge clk_48mhz);
    reset = 1'b1;
    repeat (3) @(negedge clk_48mhz);
    test_frame("after_reset", 2);
  endtask

  initial begin
    test_reset();
    test_frame("frame1", 0);
    test_frame("frame2", 2);
    test_idle_drop();
    test_resync();
    test_coincident_done();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
